// File: rtl/i2s_pkg.sv
// i2s_pkg: shared I2S framing constants, mic word type and helpers for the
// capture and playback paths.
package i2s_pkg;

  localparam int unsigned i2s_slot_bits     = 32;
  localparam int unsigned i2s_frame_bits    = 64;
  localparam int unsigned i2s_mic_data_bits = 24;
  localparam int unsigned i2s_bit_cnt_w     = $clog2(i2s_frame_bits);

  typedef logic signed [i2s_mic_data_bits-1:0] i2s_mic_word_t;
  typedef logic [i2s_bit_cnt_w-1:0]            i2s_bit_cnt_t;

  // Receiver priming: no sample is trusted until one full frame has elapsed
  typedef enum logic {
    prime_wait = 1'b0,
    prime_run  = 1'b1
  } prime_state_t;

  // True for the bit positions inside a slot that carry mic data (MSB at 1)
  function automatic logic is_capture_bit(input i2s_bit_cnt_t b);
    return (b >= i2s_bit_cnt_w'(1)) && (b <= i2s_bit_cnt_w'(i2s_mic_data_bits));
  endfunction

  // True for the last data bit of a slot, after which the word is complete
  function automatic logic is_last_bit(input i2s_bit_cnt_t b);
    return b == i2s_bit_cnt_w'(i2s_mic_data_bits);
  endfunction

  // True for the final bit position of a frame
  function automatic logic is_frame_end(input i2s_bit_cnt_t b);
    return b == i2s_bit_cnt_w'(i2s_frame_bits - 1);
  endfunction

endpackage

// File: rtl/i2s_sck_ws_gen.sv
// i2s_sck_ws_gen: divides clk into the I2S bit clock and derives the 64-bit
// frame position and word select. The rise_c/fall_c pulses mark the clk cycle
// whose active edge moves sck up or down. Shared with the I2S output path.
module i2s_sck_ws_gen
  import i2s_pkg::*;
#(
  parameter int unsigned sck_half_div = 8
) (
  input  logic         clk,
  input  logic         rst,
  output logic         sck,
  output logic         ws,
  output i2s_bit_cnt_t bit_cnt,
  output logic         rise_c,
  output logic         fall_c
);

  localparam int unsigned div_w = (sck_half_div > 1) ? $clog2(sck_half_div) : 1;
  localparam logic [div_w-1:0] div_last = div_w'(sck_half_div - 1);

  logic [div_w-1:0] div_q;
  logic             tc_c;
  i2s_bit_cnt_t     bit_cnt_inc_c;

  assign tc_c          = (div_q == div_last);
  assign rise_c        = tc_c & ~sck;
  assign fall_c        = tc_c & sck;
  assign bit_cnt_inc_c = bit_cnt + i2s_bit_cnt_w'(1);

  // Half-period divider: counts 0..sck_half_div-1 and wraps
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q <= '0;
    end else if (tc_c) begin
      div_q <= '0;
    end else begin
      div_q <= div_q + div_w'(1);
    end
  end

  // Bit clock, frame position and word select; ws moves together with the sck fall
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sck     <= 1'b0;
      bit_cnt <= '0;
      ws      <= 1'b0;
    end else begin
      if (tc_c) begin
        sck <= ~sck;
      end
      if (fall_c) begin
        bit_cnt <= bit_cnt_inc_c;
        ws      <= bit_cnt_inc_c[i2s_bit_cnt_w-1];
      end
    end
  end

endmodule

// File: rtl/i2s_mic_master_receiver.sv
// i2s_mic_master_receiver: I2S master receiver for an INMP441-class MEMS mic.
// Drives sck/ws, captures the 24-bit left-slot word MSB first and emits its
// top w_value bits with a one-clk valid strobe once per frame.
// Optional first-order DC removal is built when I2S_MIC_DC_BLOCK_EN is defined.
module i2s_mic_master_receiver
  import i2s_pkg::*;
#(
  parameter int unsigned clk_mhz      = 50,
  parameter int unsigned sck_half_div = 8,
  parameter int unsigned w_value      = 24,
  parameter int unsigned dc_shift     = 10
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      sd,
  output logic                      sck,
  output logic                      ws,
  output logic                      lr,
  output logic signed [w_value-1:0] value,
  output logic                      valid
);

  // sd is resynchronised with two flops, so it must settle 2 clk before each
  // rise event; that needs at least 4 clk per SCK half period.
  if (sck_half_div < 4 || clk_mhz == 0 || w_value < 1 ||
      w_value > i2s_mic_data_bits || dc_shift == 0) begin : g_bad_params
    $error("i2s_mic_master_receiver: illegal parameter set");
  end

  i2s_bit_cnt_t              bit_cnt;
  logic                      rise_c;
  logic                      fall_c;
  logic                      sd_meta;
  logic                      sd_sync;
  i2s_mic_word_t             shift_q;
  logic                      cap_c;
  logic                      last_c;
  logic                      strobe_pend;
  prime_state_t              prime_q;
  prime_state_t              prime_d;
  logic                      primed_c;
  logic signed [w_value-1:0] x_c;
  logic signed [w_value-1:0] y_c;

  // The mic is strapped to the left channel
  assign lr = 1'b0;

  i2s_sck_ws_gen #(
    .sck_half_div (sck_half_div)
  ) u_sck_ws_gen (
    .clk     (clk),
    .rst     (rst),
    .sck     (sck),
    .ws      (ws),
    .bit_cnt (bit_cnt),
    .rise_c  (rise_c),
    .fall_c  (fall_c)
  );

  // Two-flop synchroniser for the asynchronous mic data line
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sd_meta <= 1'b0;
      sd_sync <= 1'b0;
    end else begin
      sd_meta <= sd;
      sd_sync <= sd_meta;
    end
  end

  // Left slot bits 1..24 carry the word; bit 0 is the I2S one-bit delay
  assign cap_c  = rise_c & ~ws & is_capture_bit(bit_cnt);
  assign last_c = rise_c & ~ws & is_last_bit(bit_cnt);

  // MSB-first capture shift register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_q <= '0;
    end else if (cap_c) begin
      shift_q <= {shift_q[i2s_mic_data_bits-2:0], sd_sync};
    end
  end

  // Priming state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prime_q <= prime_wait;
    end else begin
      prime_q <= prime_d;
    end
  end

  // Priming next state: arm on the first frame wrap after reset
  always_comb begin
    prime_d  = prime_q;
    primed_c = 1'b0;
    case (prime_q)
      prime_wait: begin
        if (fall_c && is_frame_end(bit_cnt)) begin
          prime_d = prime_run;
        end
      end
      prime_run: begin
        primed_c = 1'b1;
      end
      default: begin
        prime_d = prime_wait;
      end
    endcase
  end

  // Delay the end-of-word rise by one clk so the last bit is in shift_q
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      strobe_pend <= 1'b0;
    end else begin
      strobe_pend <= last_c & primed_c;
    end
  end

  assign x_c = shift_q[i2s_mic_data_bits-1 -: w_value];

`ifdef I2S_MIC_DC_BLOCK_EN
  localparam int unsigned acc_w = w_value + dc_shift;
  localparam int unsigned ext_w = acc_w + 1;
  localparam logic signed [ext_w-1:0] y_max = ext_w'((64'sd1 <<< (w_value - 1)) - 64'sd1);
  localparam logic signed [ext_w-1:0] y_min = ~y_max;

  logic signed [acc_w-1:0] acc_q;
  logic signed [ext_w-1:0] x_ext_c;
  logic signed [ext_w-1:0] shr_ext_c;
  logic signed [ext_w-1:0] diff_c;
  logic signed [ext_w-1:0] acc_sum_c;

  // Subtract the running DC estimate and saturate back to the output width
  always_comb begin
    x_ext_c   = ext_w'(x_c);
    shr_ext_c = ext_w'(acc_q >>> dc_shift);
    diff_c    = x_ext_c - shr_ext_c;
    acc_sum_c = ext_w'(acc_q) + diff_c;
    y_c       = diff_c[w_value-1:0];
    if (diff_c > y_max) begin
      y_c = y_max[w_value-1:0];
    end else if (diff_c < y_min) begin
      y_c = y_min[w_value-1:0];
    end
  end

  // DC accumulator, advanced once per delivered sample
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
    end else if (strobe_pend) begin
      acc_q <= acc_sum_c[acc_w-1:0];
    end
  end
`else
  assign y_c = x_c;
`endif

  // Registered sample output; value holds between strobes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value <= '0;
      valid <= 1'b0;
    end else begin
      valid <= strobe_pend;
      if (strobe_pend) begin
        value <= y_c;
      end
    end
  end

endmodule

// File: tb/tb_i2s_mic_master_receiver.sv
// tb_i2s_mic_master_receiver: randomized mic model and scoreboard for the I2S
// mic receiver, with a 24-bit and a 16-bit output instance sharing one mic.
`timescale 1ns/1ps
module tb_i2s_mic_master_receiver;

  localparam int unsigned half_div   = 8;
  localparam int unsigned dc_sh      = 10;
  localparam int          frame_clks = 128 * half_div;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sd  = 1'b0;

  logic               sck, ws, lr, valid;
  logic signed [23:0] value;
  logic               sck16, ws16, lr16, valid16;
  logic signed [15:0] value16;

  always #5 clk = ~clk;

  i2s_mic_master_receiver #(
    .clk_mhz (50), .sck_half_div (half_div), .w_value (24), .dc_shift (dc_sh)
  ) u_dut (
    .clk (clk), .rst (rst), .sd (sd), .sck (sck), .ws (ws), .lr (lr),
    .value (value), .valid (valid)
  );

  i2s_mic_master_receiver #(
    .clk_mhz (50), .sck_half_div (half_div), .w_value (16), .dc_shift (dc_sh)
  ) u_dut16 (
    .clk (clk), .rst (rst), .sd (sd), .sck (sck16), .ws (ws16), .lr (lr16),
    .value (value16), .valid (valid16)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                  tag, got, got, exp, exp, $time);
  endtask

  // Mic model and scoreboard state
  int          mode = 0;
  logic [23:0] word_l, word_r;
  int          falls_since_reset = 0;
  int          rises_in_frame    = 0;
  int          cyc_since_rise    = 1000;
  longint      cyc               = 0;
  longint      last_valid_cyc    = -1;
  longint      last_frame_cyc    = -1;
  logic        prev_sck = 1'b0;
  logic        prev_ws  = 1'b0;
  logic [23:0] exp_q[$];
  int          n_push  = 0;
  int          n_valid = 0;
  longint      acc24 = 0;
  longint      acc16 = 0;

  task automatic pick_words();
    case (mode)
      1:       begin word_l = 24'h7FFFFF; word_r = 24'h000000; end
      2:       begin word_l = 24'h800001; word_r = 24'h123456; end
      3:       begin word_l = 24'h100000; word_r = 24'($urandom); end
      default: begin word_l = 24'($urandom); word_r = 24'($urandom); end
    endcase
  endtask

  function automatic longint sat(input longint y, input int w);
    longint hi, lo;
    hi = (longint'(1) <<< (w - 1)) - 1;
    lo = -hi - 1;
    if (y > hi) return hi;
    if (y < lo) return lo;
    return y;
  endfunction

  // Expected output for raw left word x, applying DC removal when it is built
  task automatic expect_out(input longint x, input int w, inout longint acc, output longint y);
`ifdef I2S_MIC_DC_BLOCK_EN
    longint d;
    d   = x - (acc >>> dc_sh);
    acc = acc + d;
    y   = sat(d, w);
`else
    acc = acc;
    y   = sat(x, w);
`endif
  endtask

  // Per-clk mic model (drives sd after each SCK fall) and output scoreboard
  always @(posedge clk) begin
    logic fell, rose;
    int   k;
    logic [23:0] w;
    longint e24, e16;
    #1;
    cyc++;
    if (rst) begin
      falls_since_reset = 0;
      rises_in_frame    = 0;
      cyc_since_rise    = 1000;
      last_valid_cyc    = -1;
      last_frame_cyc    = -1;
      prev_sck = 1'b0;
      prev_ws  = 1'b0;
      exp_q.delete();
      acc24 = 0;
      acc16 = 0;
      sd = 1'b0;
      pick_words();
    end else begin
      fell = prev_sck && !sck;
      rose = !prev_sck && sck;
      if (rose) begin
        rises_in_frame++;
        cyc_since_rise = 0;
      end else begin
        cyc_since_rise++;
      end
      if (ws !== prev_ws) check("ws_edge_on_sck_fall", longint'(fell), 1);
      if (fell) begin
        falls_since_reset++;
        k = falls_since_reset % 64;
        check("ws_level", longint'(ws), longint'(k >= 32));
        if (k == 0) begin
          if (last_frame_cyc >= 0) check("frame_period", cyc - last_frame_cyc, frame_clks);
          last_frame_cyc = cyc;
          rises_in_frame = 0;
          pick_words();
        end
        if (k >= 1 && k <= 24)       sd = word_l[24 - k];
        else if (k >= 33 && k <= 56) sd = word_r[56 - k];
        else                         sd = 1'($urandom_range(0, 1));
        if (k == 24 && falls_since_reset >= 64) begin
          exp_q.push_back(word_l);
          n_push++;
        end
      end
      if (valid || valid16) begin
        check("valid_pair", longint'(valid16), longint'(valid));
        n_valid++;
        check("valid_after_rise", cyc_since_rise, 1);
        check("valid_at_rise25", rises_in_frame, 25);
        if (last_valid_cyc >= 0) check("valid_period", cyc - last_valid_cyc, frame_clks);
        last_valid_cyc = cyc;
        if (exp_q.size() == 0) begin
          check("unexpected_valid", 1, 0);
        end else begin
          w = exp_q.pop_front();
          expect_out(longint'($signed(w)), 24, acc24, e24);
          expect_out(longint'($signed(w[23:8])), 16, acc16, e16);
          check("value24", longint'(value), e24);
          check("value16", longint'(value16), e16);
        end
      end
      prev_sck = sck;
      prev_ws  = ws;
    end
  end

  initial begin
    logic found;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_sck", longint'(sck), 0);
    check("rst_ws", longint'(ws), 0);
    check("rst_lr", longint'(lr), 0);
    check("rst_value", longint'(value), 0);
    check("rst_valid", longint'(valid), 0);
    check("rst_value16", longint'(value16), 0);
    check("rst_sck16", longint'(sck16), 0);
    check("rst_ws16", longint'(ws16), 0);
    check("rst_lr16", longint'(lr16), 0);

    @(negedge clk) rst = 1'b0;
    mode = 1; repeat (3 * frame_clks) @(posedge clk);
    mode = 2; repeat (3 * frame_clks) @(posedge clk);
    mode = 3; repeat (3 * frame_clks) @(posedge clk);
    mode = 0; repeat (4 * frame_clks) @(posedge clk);

    // Reset in the middle of left-slot bit 12 while sck is high
    found = 1'b0;
    for (int i = 0; i < 3 * frame_clks && !found; i++) begin
      @(negedge clk);
      if (falls_since_reset % 64 == 12 && sck) found = 1'b1;
    end
    check("reach_left_bit12", longint'(found), 1);
    rst = 1'b1;
    #1;
    check("async_rst_sck", longint'(sck), 0);
    check("async_rst_ws", longint'(ws), 0);
    check("async_rst_value", longint'(value), 0);
    check("async_rst_valid", longint'(valid), 0);
    check("async_rst_value16", longint'(value16), 0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    mode = 0; repeat (4 * frame_clks) @(posedge clk);

    for (int i = 0; i < 2 * frame_clks && exp_q.size() != 0; i++) @(posedge clk);
    #2;
    check("queue_drained", exp_q.size(), 0);
    check("valid_count", n_valid, n_push);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
